// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared keypad lane constants, lane index type and round-robin picker
package key_pkg;

    localparam int LANES  = 4;
    localparam int LANE_W = 2;

    typedef logic [LANE_W-1:0] lane_idx_t;

    // Returns {found, lane}: first requesting lane after 'last', wrapping.
    function automatic logic [LANE_W:0] rr_pick(input logic [LANES-1:0] req,
                                                input lane_idx_t        last);
        lane_idx_t idx;
        lane_idx_t pick;
        logic      found;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= LANES; k++) begin
            idx = last + lane_idx_t'(k);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
        return {found, pick};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with flush, registered count and full/empty flags
module sync_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    // Empty queue presents lane 0 so the head output is defined out of reset.
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        push_ok  = push & ~full;
        pop_ok   = pop & ~empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/key_event_arbiter.sv
// rtl/key_event_arbiter.sv - keypad press edge detect, pending register, round-robin grant into event queue
module key_event_arbiter
    import key_pkg::*;
#(
    parameter int LANES      = key_pkg::LANES,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [LANES-1:0]            clean,
    input  logic                        enable,
    input  logic                        clr_flags,
    input  logic                        evt_ready,
    output logic                        evt_valid,
    output logic [1:0]                  evt_lane,
    output logic [LANES-1:0]            pending,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        dropped
);

    logic [LANES-1:0] prev_q, prev_d;
    logic             armed_q, armed_d;
    logic [LANES-1:0] pending_q, pending_d;
    lane_idx_t        last_grant_q, last_grant_d;
    logic             dropped_q, dropped_d;

    logic [LANES-1:0] press;
    logic [LANES-1:0] grant_vec;
    logic             grant_found, grant_vld, drop;
    lane_idx_t        grant_idx;
    logic             fifo_full, fifo_empty;
    lane_idx_t        head_lane;

    always_comb begin
        prev_d  = clean;
        armed_d = 1'b1;
        // Lanes already held at reset release must not look like fresh presses.
        press   = armed_q ? (prev_q & ~clean) : '0;

        {grant_found, grant_idx} = rr_pick(pending_q, last_grant_q);
        grant_vld = enable & ~fifo_full & grant_found;
        grant_vec = '0;
        if (grant_vld) begin
            grant_vec[grant_idx] = 1'b1;
        end

        last_grant_d = grant_vld ? grant_idx : last_grant_q;

        if (enable) begin
            // A press on the lane being granted this cycle re-arms it without a drop.
            drop      = |(press & pending_q & ~grant_vec);
            pending_d = (pending_q & ~grant_vec) | press;
        end else begin
            drop      = 1'b0;
            pending_d = '0;
        end

        if (drop) begin
            dropped_d = 1'b1;
        end else if (clr_flags) begin
            dropped_d = 1'b0;
        end else begin
            dropped_d = dropped_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q       <= '1;
            armed_q      <= 1'b0;
            pending_q    <= '0;
            last_grant_q <= lane_idx_t'(LANES - 1);
            dropped_q    <= 1'b0;
        end else begin
            prev_q       <= prev_d;
            armed_q      <= armed_d;
            pending_q    <= pending_d;
            last_grant_q <= last_grant_d;
            dropped_q    <= dropped_d;
        end
    end

    sync_fifo #(
        .WIDTH (LANE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_evt_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (~enable),
        .push      (grant_vld),
        .push_data (grant_idx),
        .pop       (evt_ready & ~fifo_empty),
        .pop_data  (head_lane),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign evt_valid = ~fifo_empty;
    assign evt_lane  = head_lane;
    assign pending   = pending_q;
    assign dropped   = dropped_q;

endmodule
